// File: rtl/avl_test_pkg.sv
// avl_test_pkg: shared state encoding and constants for the Avalon burst traffic tester
package avl_test_pkg;
  localparam int AVL_SIZE_W = 8;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/avl_test_lfsr.sv
// avl_test_lfsr: W-bit Fibonacci LFSR with enable and synchronous load
module avl_test_lfsr #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o
);
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TAPS =
    W == 128 ? (ONE << 127) | (ONE << 125) | (ONE << 100) | (ONE << 98) :
    W == 64  ? (ONE << 63) | (ONE << 62) | (ONE << 60) | (ONE << 59) :
    W == 32  ? (ONE << 31) | (ONE << 21) | (ONE << 1) | ONE :
               (ONE << (W - 1)) | (ONE << (W - 2));
  always_ff @(posedge clk) begin
    if (load_i) q_o <= load_val_i;
    else if (en_i) q_o <= {q_o[W-2:0], ^(q_o & TAPS)};
  end
endmodule

// File: rtl/avalon_burst_rw_tester.sv
// avalon_burst_rw_tester: burst write/read-back LFSR memory tester for an Avalon-MM slave
module avalon_burst_rw_tester import avl_test_pkg::*; #(
  parameter int          ADDR_W          = 26,
  parameter int          DATA_W          = 128,
  parameter int          BURST_LEN       = 4,
  parameter int          ADDR_BASE       = 0,
  parameter int          ADDR_SPAN       = 2**26,
  parameter int          NUM_PASSES      = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] LFSR_SEED       = 32'h3E0F0E32,
  parameter int          ERR_CNT_W       = 16
) (
  input  logic                  iCLK,
  input  logic                  iRST_n,
  input  logic                  iSTART,
  input  logic                  iINSERT_ERROR,
  input  logic                  avl_waitrequest,
  input  logic                  avl_readdatavalid,
  input  logic [DATA_W-1:0]     avl_readdata,
  output logic [ADDR_W-1:0]     avl_address,
  output logic [DATA_W-1:0]     avl_writedata,
  output logic                  avl_read,
  output logic                  avl_write,
  output logic                  avl_burstbegin,
  output logic [AVL_SIZE_W-1:0] avl_size,
  output logic                  drv_status_pass,
  output logic                  drv_status_fail,
  output logic                  drv_status_test_complete,
  output logic [ERR_CNT_W-1:0]  oERR_COUNT,
  output logic [ADDR_W-1:0]     oFIRST_ERR_ADDR
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W:0] LAST_B = (ADDR_W + 1)'(ADDR_SPAN / BURST_LEN - 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING * BURST_LEN + 1) + 1;
  localparam logic [OUT_W-1:0] BL_O = OUT_W'(BURST_LEN);
  localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTSTANDING * BURST_LEN);
  localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, rd_word_q, first_q, cmp_addr_q;
  logic [ADDR_W:0] bcnt_q;
  logic [7:0] beat_q;
  logic [OUT_W-1:0] out_q;
  logic [31:0] pass_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic fail_q, done_q, cmp_v_q;
  logic [DATA_W-1:0] wr_lfsr, rd_lfsr, cmp_data_q, cmp_exp_q;
  logic wr_acc, rd_acc, beat_v, last_b, last_beat, drained, more, pass_start, restart;
  assign avl_write = state_q == S_WRITE;
  assign avl_read = state_q == S_READ && out_q + BL_O <= MAX_O;
  assign wr_acc = avl_write && !avl_waitrequest;
  assign rd_acc = avl_read && !avl_waitrequest;
  assign beat_v = avl_readdatavalid && (state_q == S_READ || state_q == S_DRAIN);
  assign last_b = bcnt_q == LAST_B;
  assign last_beat = beat_q == 8'(BURST_LEN - 1);
  assign drained = state_q == S_DRAIN && out_q == '0 && !cmp_v_q;
  assign more = NUM_PASSES == 0 || pass_q + 32'd1 < 32'(NUM_PASSES);
  assign restart = iSTART && (state_q == S_IDLE || state_q == S_DONE);
  assign pass_start = restart || (drained && more);
  assign state_d = pass_start ? S_WRITE :
                   wr_acc && last_beat && last_b ? S_READ :
                   rd_acc && last_b ? S_DRAIN :
                   drained ? S_DONE : state_q;
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      rd_word_q <= '0;
      first_q <= '0;
      cmp_addr_q <= '0;
      bcnt_q <= '0;
      beat_q <= '0;
      out_q <= '0;
      pass_q <= '0;
      err_q <= '0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
      cmp_v_q <= 1'b0;
      cmp_data_q <= '0;
      cmp_exp_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_q + (rd_acc ? BL_O : '0) - OUT_W'(beat_v);
      cmp_v_q <= beat_v;
      cmp_data_q <= avl_readdata;
      cmp_exp_q <= rd_lfsr ^ DATA_W'(iINSERT_ERROR);
      cmp_addr_q <= rd_word_q;
      if (beat_v) rd_word_q <= rd_word_q + 1'b1;
      if (cmp_v_q && cmp_data_q != cmp_exp_q) begin
        fail_q <= 1'b1;
        if (err_q == '0) first_q <= cmp_addr_q;
        if (err_q != '1) err_q <= err_q + 1'b1;
      end
      if (wr_acc) beat_q <= last_beat ? '0 : beat_q + 1'b1;
      if ((wr_acc && last_beat) || rd_acc) begin
        addr_q <= last_b ? BASE : addr_q + STEP;
        bcnt_q <= last_b ? '0 : bcnt_q + 1'b1;
      end
      if (drained) pass_q <= pass_q + 1'b1;
      if (drained && !more) done_q <= 1'b1;
      if (pass_start) begin
        addr_q <= BASE;
        bcnt_q <= '0;
        beat_q <= '0;
        rd_word_q <= BASE;
      end
      if (restart) begin
        fail_q <= 1'b0;
        err_q <= '0;
        first_q <= '0;
        done_q <= 1'b0;
        pass_q <= '0;
      end
    end
  end
  // read LFSR snapshots the write LFSR at every pass start so each pass checks its own data
  avl_test_lfsr #(.W(DATA_W)) u_wr_lfsr (
    .clk(iCLK), .en_i(wr_acc), .load_i(!iRST_n), .load_val_i(SEED), .q_o(wr_lfsr)
  );
  avl_test_lfsr #(.W(DATA_W)) u_rd_lfsr (
    .clk(iCLK), .en_i(beat_v), .load_i(!iRST_n || pass_start),
    .load_val_i(iRST_n ? wr_lfsr : SEED), .q_o(rd_lfsr)
  );
  assign avl_address = addr_q;
  assign avl_writedata = avl_write ? wr_lfsr : '0;
  assign avl_burstbegin = (avl_write && beat_q == '0) || avl_read;
  assign avl_size = AVL_SIZE_W'(BURST_LEN);
  assign drv_status_fail = fail_q;
  assign drv_status_test_complete = done_q;
  assign drv_status_pass = done_q && err_q == '0;
  assign oERR_COUNT = err_q;
  assign oFIRST_ERR_ADDR = first_q;
endmodule

// File: tb/tb_avalon_burst_rw_tester.sv
// tb_avalon_burst_rw_tester: memory slave model plus scenario tasks for the burst tester
module tb_avalon_burst_rw_tester;
  localparam int AW = 8, DW = 32, BL = 4, BASE = 32, SPAN = 64, NP = 3, MO = 2, EW = 7;
  localparam logic [DW-1:0] SEED = 32'h3E0F0E32;
  localparam int NWR = NP * SPAN, NRD = NP * SPAN / BL, ESAT = (1 << EW) - 1;
  logic clk = 0, rst_n = 0, start = 0, ins = 0, wreq = 0, rdv = 0;
  logic [DW-1:0] rdata = '0;
  logic [AW-1:0] avl_address, oFIRST_ERR_ADDR;
  logic [DW-1:0] avl_writedata;
  logic avl_read, avl_write, avl_burstbegin, drv_status_pass, drv_status_fail, drv_status_test_complete;
  logic [7:0] avl_size;
  logic [EW-1:0] oERR_COUNT;
  avalon_burst_rw_tester #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .ADDR_BASE(BASE), .ADDR_SPAN(SPAN),
    .NUM_PASSES(NP), .MAX_OUTSTANDING(MO), .ERR_CNT_W(EW)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iSTART(start), .iINSERT_ERROR(ins),
    .avl_waitrequest(wreq), .avl_readdatavalid(rdv), .avl_readdata(rdata),
    .avl_address(avl_address), .avl_writedata(avl_writedata), .avl_read(avl_read),
    .avl_write(avl_write), .avl_burstbegin(avl_burstbegin), .avl_size(avl_size),
    .drv_status_pass(drv_status_pass), .drv_status_fail(drv_status_fail),
    .drv_status_test_complete(drv_status_test_complete), .oERR_COUNT(oERR_COUNT),
    .oFIRST_ERR_ADDR(oFIRST_ERR_ADDR)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, cyc = 0, lat = 5, wait_pct = 0, inflight = 0, max_inflight = 0;
  int stall_viol = 0, stalls_seen = 0, issue_gaps = 0, exp_err = 0, bb_err = 0;
  bit corrupt_en = 0, first_set = 0, prev_stalled = 0;
  logic [AW-1:0] exp_first = '0, a, p_addr;
  logic [AW-1:0] corrupt_addr = 8'h22;
  logic [DW-1:0] p_data, run1_first;
  logic p_w, p_r;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] wdata_q [$];
  logic [AW-1:0] waddr_q [$], raddr_q [$], due_addr [$];
  int due_cyc [$];
  // slave: inputs for the next rising edge are chosen on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      due_cyc.delete();
      due_addr.delete();
      inflight = 0;
      prev_stalled = 0;
      wreq = 0;
      rdv = 0;
    end else begin
      if (prev_stalled) begin
        stalls_seen++;
        if ({avl_address, avl_writedata, avl_write, avl_read} !== {p_addr, p_data, p_w, p_r}) stall_viol++;
      end
      wreq = $urandom_range(99) < wait_pct;
      if (avl_write && !wreq) begin
        if (avl_burstbegin !== (wdata_q.size() % BL == 0)) bb_err++;
        mem[avl_address + AW'(wdata_q.size() % BL)] = avl_writedata;
        wdata_q.push_back(avl_writedata);
        waddr_q.push_back(avl_address);
      end
      if (!avl_read && inflight >= MO * BL && raddr_q.size() % (SPAN / BL) != 0) issue_gaps++;
      if (avl_read && !wreq) begin
        raddr_q.push_back(avl_address);
        for (int k = 0; k < BL; k++) begin
          due_cyc.push_back(cyc + lat + k);
          due_addr.push_back(avl_address + AW'(k));
        end
        inflight += BL;
      end
      rdv = 0;
      rdata = $urandom;
      if (due_cyc.size() > 0 && due_cyc[0] <= cyc) begin
        void'(due_cyc.pop_front());
        a = due_addr.pop_front();
        rdv = 1;
        rdata = mem[a] ^ DW'(corrupt_en && a == corrupt_addr);
        inflight--;
        if (ins || (corrupt_en && a == corrupt_addr)) begin
          if (!first_set) exp_first = a;
          first_set = 1;
          exp_err++;
        end
      end
      if (inflight > max_inflight) max_inflight = inflight;
      prev_stalled = (avl_write || avl_read) && wreq;
      p_addr = avl_address;
      p_data = avl_writedata;
      p_w = avl_write;
      p_r = avl_read;
    end
  end
  task automatic start_test(input int l, input int wp, input bit ce, input bit in_err);
    @(negedge clk);
    lat = l; wait_pct = wp; corrupt_en = ce; ins = in_err;
    wdata_q.delete(); waddr_q.delete(); raddr_q.delete();
    max_inflight = 0; stall_viol = 0; stalls_seen = 0; issue_gaps = 0;
    exp_err = 0; first_set = 0; bb_err = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!drv_status_test_complete && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (drv_status_test_complete !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: test_complete=%0b after %0d cycles, required 1", name, drv_status_test_complete, n);
    end
    ins = 0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin} !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h rd=%b wr=%b bb=%b, required all 0", avl_address, avl_writedata, avl_read, avl_write, avl_burstbegin);
    end
    checks++;
    if ({drv_status_pass, drv_status_fail, drv_status_test_complete, oERR_COUNT, oFIRST_ERR_ADDR} !== '0) begin
      errors++;
      $display("FAIL reset_status: pass=%b fail=%b cmp=%b cnt=%0d first=%h, required all 0", drv_status_pass, drv_status_fail, drv_status_test_complete, oERR_COUNT, oFIRST_ERR_ADDR);
    end
    checks++;
    if (avl_size !== 8'(BL)) begin errors++; $display("FAIL reset_size: got %0d, required %0d", avl_size, BL); end
  endtask
  task automatic test_basic();
    int bad = 0, same = 0;
    start_test(5, 0, 0, 0);
    checks++;
    if (avl_address !== AW'(BASE) || avl_write !== 1'b1 || avl_writedata !== SEED) begin
      errors++;
      $display("FAIL basic_first_beat: addr=%h wr=%b data=%h, required %h 1 %h", avl_address, avl_write, avl_writedata, AW'(BASE), SEED);
    end
    wait_done("basic");
    checks++;
    if (drv_status_pass !== 1'b1 || drv_status_fail !== 1'b0) begin errors++; $display("FAIL basic_status: pass=%b fail=%b, required 1 0", drv_status_pass, drv_status_fail); end
    checks++;
    if (oERR_COUNT !== EW'(exp_err)) begin errors++; $display("FAIL basic_count: got %0d, required %0d", oERR_COUNT, exp_err); end
    checks++;
    if (wdata_q.size() != NWR || raddr_q.size() != NRD) begin errors++; $display("FAIL basic_beats: writes=%0d reads=%0d, required %0d %0d", wdata_q.size(), raddr_q.size(), NWR, NRD); end
    for (int i = 0; i < wdata_q.size(); i++) if (waddr_q[i] !== AW'(BASE + (i % SPAN) / BL * BL)) bad++;
    for (int i = 0; i < raddr_q.size(); i++) if (raddr_q[i] !== AW'(BASE + (i % (SPAN / BL)) * BL)) bad++;
    checks++;
    if (bad != 0 || bb_err != 0) begin errors++; $display("FAIL basic_addr: %0d address errors, %0d burstbegin errors, required 0 0", bad, bb_err); end
    for (int p = 1; p < NP; p++) for (int j = 0; j < SPAN; j++) if (wdata_q.size() == NWR && wdata_q[p * SPAN + j] === wdata_q[j]) same++;
    checks++;
    if (same != 0) begin errors++; $display("FAIL basic_pass_data: %0d beats repeat pass 1 data, required 0", same); end
    checks++;
    if (max_inflight != MO * BL) begin errors++; $display("FAIL basic_inflight: max %0d, required %0d", max_inflight, MO * BL); end
    run1_first = wdata_q[0];
  endtask
  task automatic test_stall();
    start_test(5, 50, 0, 0);
    checks++;
    if (drv_status_test_complete !== 1'b0 || drv_status_pass !== 1'b0) begin errors++; $display("FAIL stall_restart_clear: cmp=%b pass=%b, required 0 0", drv_status_test_complete, drv_status_pass); end
    checks++;
    if (avl_writedata === run1_first) begin errors++; $display("FAIL stall_no_reload: data=%h, required differ from %h", avl_writedata, run1_first); end
    wait_done("stall");
    checks++;
    if (stall_viol != 0 || stalls_seen == 0) begin errors++; $display("FAIL stall_hold: %0d changes over %0d stalls, required 0 over >0", stall_viol, stalls_seen); end
    checks++;
    if (drv_status_pass !== 1'b1 || wdata_q.size() != NWR) begin errors++; $display("FAIL stall_pass: pass=%b writes=%0d, required 1 %0d", drv_status_pass, wdata_q.size(), NWR); end
  endtask
  task automatic test_corrupt();
    start_test(5, 0, 1, 0);
    wait_done("corrupt");
    checks++;
    if (drv_status_fail !== 1'b1 || drv_status_pass !== 1'b0) begin errors++; $display("FAIL corrupt_status: fail=%b pass=%b, required 1 0", drv_status_fail, drv_status_pass); end
    checks++;
    if (oERR_COUNT !== EW'(exp_err) || exp_err != NP) begin errors++; $display("FAIL corrupt_count: got %0d, required %0d", oERR_COUNT, NP); end
    checks++;
    if (oFIRST_ERR_ADDR !== exp_first) begin errors++; $display("FAIL corrupt_first: got %h, required %h", oFIRST_ERR_ADDR, exp_first); end
  endtask
  task automatic test_outstanding();
    start_test(20, 0, 0, 0);
    checks++;
    if (drv_status_fail !== 1'b0 || oERR_COUNT !== '0 || oFIRST_ERR_ADDR !== '0) begin errors++; $display("FAIL out_restart_clear: fail=%b cnt=%0d first=%h, required 0 0 0", drv_status_fail, oERR_COUNT, oFIRST_ERR_ADDR); end
    wait_done("outstanding");
    checks++;
    if (max_inflight != MO * BL || issue_gaps == 0) begin errors++; $display("FAIL out_limit: max %0d gaps %0d, required %0d and >0", max_inflight, issue_gaps, MO * BL); end
    checks++;
    if (drv_status_pass !== 1'b1) begin errors++; $display("FAIL out_pass: got %b, required 1", drv_status_pass); end
  endtask
  task automatic test_insert_saturate();
    start_test(5, 0, 0, 1);
    wait_done("insert");
    checks++;
    if (oERR_COUNT !== EW'(exp_err > ESAT ? ESAT : exp_err)) begin errors++; $display("FAIL insert_count: got %0d, required %0d", oERR_COUNT, exp_err > ESAT ? ESAT : exp_err); end
    checks++;
    if (oFIRST_ERR_ADDR !== exp_first || drv_status_fail !== 1'b1 || drv_status_pass !== 1'b0) begin errors++; $display("FAIL insert_status: first=%h fail=%b pass=%b, required %h 1 0", oFIRST_ERR_ADDR, drv_status_fail, drv_status_pass, exp_first); end
  endtask
  task automatic test_reset_mid_read();
    int n = 0;
    start_test(5, 0, 0, 0);
    while (avl_read !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (avl_read !== 1'b1) begin errors++; $display("FAIL midrd_reach: read=%b after %0d cycles, required 1", avl_read, n); end
    repeat (3) @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({drv_status_pass, drv_status_fail, drv_status_test_complete, oERR_COUNT, oFIRST_ERR_ADDR, avl_read, avl_write, avl_address} !== '0) begin
      errors++;
      $display("FAIL midrd_cleared: pass=%b fail=%b cmp=%b cnt=%0d first=%h rd=%b wr=%b addr=%h, required all 0", drv_status_pass, drv_status_fail, drv_status_test_complete, oERR_COUNT, oFIRST_ERR_ADDR, avl_read, avl_write, avl_address);
    end
    start_test(5, 0, 0, 0);
    checks++;
    if (avl_address !== AW'(BASE) || avl_write !== 1'b1 || avl_burstbegin !== 1'b1 || avl_writedata !== SEED) begin
      errors++;
      $display("FAIL midrd_restart: addr=%h wr=%b bb=%b data=%h, required %h 1 1 %h", avl_address, avl_write, avl_burstbegin, avl_writedata, AW'(BASE), SEED);
    end
    wait_done("midrd");
    checks++;
    if (drv_status_pass !== 1'b1 || wdata_q.size() != NWR) begin errors++; $display("FAIL midrd_pass: pass=%b writes=%0d, required 1 %0d", drv_status_pass, wdata_q.size(), NWR); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_outstanding();
    test_insert_saturate();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
